// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit that owns the HI/LO registers.
// Long operations (MULT/MULTU/DIV/DIVU) latch their operands, hold busy for a
// fixed number of cycles and then commit the result to HI/LO on the edge that
// clears busy.  MTHI/MTLO write HI/LO directly when the unit is idle.
// The arithmetic is single-cycle combinational logic on the latched operands;
// a down-counter provides the architectural latency.
// Optional feature macro: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (md_op 7..10); without it those encodings behave as NOP.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic        rd_hi,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi_lo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } md_op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic             load_s;
    logic [CNT_W-1:0] load_cnt_s;

    logic             signed_op_s;
    logic [63:0]      a_ext_s;
    logic [63:0]      b_ext_s;
    logic [63:0]      prod_s;
    logic [31:0]      abs_a_s;
    logic [31:0]      abs_b_s;
    logic [31:0]      div_num_s;
    logic [31:0]      div_den_s;
    logic [31:0]      quo_mag_s;
    logic [31:0]      rem_mag_s;
    logic [31:0]      quo_s;
    logic [31:0]      rem_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;

    assign busy      = busy_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign hi_lo_out = rd_hi ? hi_r : lo_r;

    // Decide whether an incoming op starts a multi-cycle operation and its latency.
    always_comb begin
        load_s     = 1'b0;
        load_cnt_s = CNT_ZERO;
        if (start && !busy_r) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    load_s     = 1'b1;
                    load_cnt_s = MULT_LOAD;
                end
                OP_DIV, OP_DIVU: begin
                    load_s     = 1'b1;
                    load_cnt_s = DIV_LOAD;
                end
`ifdef MD_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    load_s     = 1'b1;
                    load_cnt_s = MULT_LOAD;
                end
`endif
                default: begin
                    load_s     = 1'b0;
                    load_cnt_s = CNT_ZERO;
                end
            endcase
        end else begin
            load_s     = 1'b0;
            load_cnt_s = CNT_ZERO;
        end
    end

    // Single-cycle arithmetic on the latched operands; only sampled at commit time.
    always_comb begin
        signed_op_s = (op_r == OP_MULT) || (op_r == OP_DIV) ||
                      (op_r == OP_MADD) || (op_r == OP_MSUB);
        a_ext_s = signed_op_s ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
        b_ext_s = signed_op_s ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
        // The low 64 bits of the extended product are correct for both signednesses.
        prod_s  = a_ext_s * b_ext_s;

        // Signed division runs on magnitudes; 0x80000000 / -1 then naturally
        // yields quotient 0x80000000 and remainder 0.
        abs_a_s   = a_r[31] ? (32'd0 - a_r) : a_r;
        abs_b_s   = b_r[31] ? (32'd0 - b_r) : b_r;
        div_num_s = signed_op_s ? abs_a_s : a_r;
        div_den_s = signed_op_s ? abs_b_s : b_r;
        if (div_den_s == 32'd0) begin
            div_den_s = 32'd1;
        end else begin
            div_den_s = div_den_s;
        end
        quo_mag_s = div_num_s / div_den_s;
        rem_mag_s = div_num_s % div_den_s;
        quo_s = (signed_op_s && (a_r[31] ^ b_r[31])) ? (32'd0 - quo_mag_s) : quo_mag_s;
        rem_s = (signed_op_s && a_r[31]) ? (32'd0 - rem_mag_s) : rem_mag_s;

        res_hi_s = hi_r;
        res_lo_s = lo_r;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                {res_hi_s, res_lo_s} = prod_s;
            end
            OP_DIV, OP_DIVU: begin
                if (b_r == 32'd0) begin
                    res_lo_s = 32'hFFFF_FFFF;
                    res_hi_s = a_r;
                end else begin
                    res_lo_s = quo_s;
                    res_hi_s = rem_s;
                end
            end
`ifdef MD_MADD_EN
            // HI/LO cannot change while busy, so the current value is the value at start.
            OP_MADD, OP_MADDU: begin
                {res_hi_s, res_lo_s} = {hi_r, lo_r} + prod_s;
            end
            OP_MSUB, OP_MSUBU: begin
                {res_hi_s, res_lo_s} = {hi_r, lo_r} - prod_s;
            end
`endif
            default: begin
                res_hi_s = hi_r;
                res_lo_s = lo_r;
            end
        endcase
    end

    // HI/LO, operand latches and the latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            op_r   <= 4'd0;
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
        end else if (busy_r) begin
            if (cnt_r == CNT_ONE) begin
                hi_r   <= res_hi_s;
                lo_r   <= res_lo_s;
                cnt_r  <= CNT_ZERO;
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else if (load_s) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= md_op;
            cnt_r  <= load_cnt_s;
            busy_r <= 1'b1;
        end else if (start && (md_op == OP_MTHI)) begin
            hi_r <= a;
        end else if (start && (md_op == OP_MTLO)) begin
            lo_r <= a;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// operations checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic        rd_hi;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi_lo_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .rd_hi(rd_hi),
        .a(a), .b(b), .busy(busy), .hi_lo_out(hi_lo_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: new HI/LO and expected busy length for one accepted op.
    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] mh, inout logic [31:0] ml, output int lat);
        int sx;
        int sy;
        longint sp;
        logic [63:0] acc;
        logic [63:0] p;
        sx = x;
        sy = y;
        lat = 0;
        case (op)
            4'd1: begin sp = longint'(sx) * longint'(sy); {mh, ml} = sp; lat = MC; end
            4'd2: begin acc = {32'd0, x} * {32'd0, y}; {mh, ml} = acc; lat = MC; end
            4'd3: begin
                lat = DC;
                if (y == 32'd0) begin ml = 32'hFFFFFFFF; mh = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin ml = 32'h80000000; mh = 32'd0; end
                else begin ml = sx / sy; mh = sx % sy; end
            end
            4'd4: begin
                lat = DC;
                if (y == 32'd0) begin ml = 32'hFFFFFFFF; mh = x; end
                else begin ml = x / y; mh = x % y; end
            end
            4'd5: mh = x;
            4'd6: ml = x;
`ifdef MD_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (op == 4'd7 || op == 4'd9) begin
                    sp = longint'(sx) * longint'(sy);
                    p = sp;
                end else begin
                    p = {32'd0, x} * {32'd0, y};
                end
                acc = {mh, ml};
                acc = (op <= 4'd8) ? acc + p : acc - p;
                {mh, ml} = acc;
                lat = MC;
            end
`endif
            default: ;
        endcase
    endtask

    // Issue one op, scramble operands after the start edge, count busy cycles.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int cycles, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        start = 1'b1; md_op = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0; a = $urandom; b = $urandom;
        mid_hi = hi; mid_lo = lo;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0; rd_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    // Directed single ops with known results and latencies.
    task automatic test_directed(input string nm, input logic [3:0] op, input logic [31:0] x,
                                 input logic [31:0] y, input int want_cyc,
                                 input logic [31:0] want_hi, input logic [31:0] want_lo);
        int cyc;
        logic [31:0] mh;
        logic [31:0] ml;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = hi; old_lo = lo;
        run_op(op, x, y, cyc, mh, ml);
        n_cmp++; if (cyc != want_cyc) begin n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, cyc, want_cyc); end
        if (want_cyc > 0) begin
            n_cmp++; if (mh !== old_hi || ml !== old_lo) begin n_err++; $display("FAIL %s_mid got %h_%h want %h_%h", nm, mh, ml, old_hi, old_lo); end
        end
        n_cmp++; if (hi !== want_hi) begin n_err++; $display("FAIL %s_hi got %h want %h", nm, hi, want_hi); end
        n_cmp++; if (lo !== want_lo) begin n_err++; $display("FAIL %s_lo got %h want %h", nm, lo, want_lo); end
        m_hi = hi; m_lo = lo;
    endtask

    task automatic test_mthi_read();
        rd_hi = 1'b1; #1;
        n_cmp++; if (hi_lo_out !== 32'h1234) begin n_err++; $display("FAIL mthi_read got %h want 00001234", hi_lo_out); end
        rd_hi = 1'b0; #1;
        n_cmp++; if (hi_lo_out !== 32'h80000000) begin n_err++; $display("FAIL mflo_read got %h want 80000000", hi_lo_out); end
    endtask

    // Start while busy is ignored; reset mid-operation aborts with no late write.
    task automatic test_ignore_and_abort();
        start = 1'b1; md_op = 4'd1; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; md_op = 4'd6; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        n_cmp++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL ignore_mtlo got %h want 80000000", lo); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy got %h want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++; $display("FAIL abort_state got busy=%h hi=%h lo=%h want 0/0/0", busy, hi, lo); end
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++; $display("FAIL abort_late got busy=%h hi=%h lo=%h want 0/0/0", busy, hi, lo); end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_madd();
        int cyc;
        logic [31:0] mh;
        logic [31:0] ml;
        run_op(4'd5, 32'd0, 32'd0, cyc, mh, ml);
        run_op(4'd6, 32'hFFFFFFFF, 32'd0, cyc, mh, ml);
        run_op(4'd8, 32'd1, 32'd1, cyc, mh, ml);
`ifdef MD_MADD_EN
        n_cmp++; if (cyc != MC) begin n_err++; $display("FAIL maddu_cycles got %0d want %0d", cyc, MC); end
        n_cmp++; if (hi !== 32'd1 || lo !== 32'd0) begin n_err++; $display("FAIL maddu_result got %h_%h want 00000001_00000000", hi, lo); end
`else
        n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL maddu_off_cycles got %0d want 0", cyc); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL maddu_off_result got %h_%h want 00000000_ffffffff", hi, lo); end
`endif
        m_hi = hi; m_lo = lo;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Random back-to-back ops against the model.
    task automatic test_random();
        int cyc;
        int lat;
        logic [3:0] op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] mh;
        logic [31:0] ml;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] want_out;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x = pick_operand();
            y = pick_operand();
            old_hi = m_hi; old_lo = m_lo;
            model(op, x, y, m_hi, m_lo, lat);
            run_op(op, x, y, cyc, mh, ml);
            n_cmp++; if (cyc != lat) begin n_err++; $display("FAIL rnd%0d_cycles op=%0d got %0d want %0d", i, op, cyc, lat); end
            if (lat > 0) begin
                n_cmp++; if (mh !== old_hi || ml !== old_lo) begin
                    n_err++; $display("FAIL rnd%0d_mid op=%0d got %h_%h want %h_%h", i, op, mh, ml, old_hi, old_lo); end
            end
            n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
                n_err++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h_%h want %h_%h", i, op, x, y, hi, lo, m_hi, m_lo); end
            rd_hi = 1'($urandom_range(0, 1));
            #1;
            want_out = rd_hi ? m_hi : m_lo;
            n_cmp++; if (hi_lo_out !== want_out) begin
                n_err++; $display("FAIL rnd%0d_read rd_hi=%0d got %h want %h", i, rd_hi, hi_lo_out, want_out); end
        end
    endtask

    initial begin
        test_reset();
        test_directed("mult",  4'd1, 32'hFFFFFFFD, 32'd7, MC, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_directed("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'hFFFFFFFE, 32'h00000001);
        test_directed("div",   4'd3, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_directed("divu0", 4'd4, 32'd7, 32'd0, DC, 32'h00000007, 32'hFFFFFFFF);
        test_directed("div0s", 4'd3, 32'hFFFFFFF9, 32'd0, DC, 32'hFFFFFFF9, 32'hFFFFFFFF);
        test_directed("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000);
        test_directed("mthi",  4'd5, 32'h1234, 32'd0, 0, 32'h00001234, 32'h80000000);
        test_mthi_read();
        test_directed("nop",   4'd0, 32'h55, 32'h66, 0, 32'h00001234, 32'h80000000);
        test_directed("undef", 4'd13, 32'h55, 32'h66, 0, 32'h00001234, 32'h80000000);
        test_ignore_and_abort();
        test_madd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
